// File: rtl/bcd_7seg_scan.sv
// Multiplexed 7-segment driver for packed BCD words, committed to the display only at frame wrap.
// Latency: seg/an trail idx/shadow by 1 clk; backpressure: none, load is always accepted (last wins).
module bcd_7seg_scan #(
  parameter int NDIG           = 3,
  parameter int CLK_DIV        = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LZ       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] bcd_in,
  input  logic              load,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   an,
  output logic              pending,
  output logic              frame_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;

  logic [DW-1:0]     div_cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] stage;
  logic [4*NDIG-1:0] shadow;

  logic              tick;
  logic              wrap;
  logic [NDIG-1:0]   blank;
  logic              zrun;
  logic [3:0]        cur_dig;
  logic              cur_blank;
  logic [6:0]        lit;
  logic [6:0]        seg_nxt;
  logic [NDIG-1:0]   an_nxt;

  // Lit pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b0111111;
      4'd1:    r = 7'b0000110;
      4'd2:    r = 7'b1011011;
      4'd3:    r = 7'b1001111;
      4'd4:    r = 7'b1100110;
      4'd5:    r = 7'b1101101;
      4'd6:    r = 7'b1111101;
      4'd7:    r = 7'b0000111;
      4'd8:    r = 7'b1111111;
      4'd9:    r = 7'b1101111;
      default: r = 7'b1000000;
    endcase
    return r;
  endfunction

  assign tick = (div_cnt == DW'(CLK_DIV - 1));
  assign wrap = tick && (idx == IW'(NDIG - 1));

  // Scan from the top digit down: a digit blanks while everything above it is still zero.
  always_comb begin
    blank = '0;
    zrun  = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zrun = zrun && (shadow[4*k +: 4] == 4'd0);
      blank[k] = (BLANK_LZ != 0) && (k != 0) && zrun;
    end
  end

  always_comb begin
    cur_dig   = 4'd0;
    cur_blank = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == IW'(k)) begin
        cur_dig   = shadow[4*k +: 4];
        cur_blank = blank[k];
      end
    end
  end

  always_comb begin
    lit     = dec7(cur_dig);
    seg_nxt = SEG_OFF;
    an_nxt  = '1;
    if (!cur_blank) begin
      seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
      an_nxt  = ~(NDIG'(1) << idx);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      idx        <= '0;
      stage      <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= SEG_OFF;
      an         <= '1;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      frame_done <= wrap;
      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end
      // A load landing on the wrap tick skips staging and shows from digit 0 of the next frame.
      if (wrap) begin
        if (load) begin
          shadow  <= bcd_in;
          stage   <= bcd_in;
          pending <= 1'b0;
        end else if (pending) begin
          shadow  <= stage;
          pending <= 1'b0;
        end
      end else if (load) begin
        stage   <= bcd_in;
        pending <= 1'b1;
      end
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule
